// File: rtl/key_filter.sv
// Push-button debouncer: two-flop synchronizer, consecutive-sample counter and a
// four-state filter FSM producing a clean level plus registered press/release pulses.
module key_filter #(
    parameter int unsigned CNT_MAX = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CntW = $clog2(CNT_MAX + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntZero = '0;
    // Last count before acceptance: the accepting sample itself is the CNT_MAX-th.
    localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressFlt,
        StDown,
        StReleaseFlt
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Synchronizer resets to the released level so a held key is not seen as pressed early.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= CntZero;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (!sync2_q) begin
                    state_d = StPressFlt;
                    cnt_d   = CntOne;
                end
            end
            StPressFlt: begin
                if (sync2_q) begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                end else if (cnt_q == CntLast) begin
                    state_d = StDown;
                    cnt_d   = CntZero;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StDown: begin
                if (sync2_q) begin
                    state_d = StReleaseFlt;
                    cnt_d   = CntOne;
                end
            end
            StReleaseFlt: begin
                if (!sync2_q) begin
                    state_d = StDown;
                    cnt_d   = CntZero;
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    cnt_d     = CntZero;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = CntZero;
            end
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter with CNT_MAX=4: stimulus queues expected pulses,
// a negedge monitor pops and compares them; a random phase checks pulse properties.
module tb_key_filter;

    localparam int unsigned CntMax = 4;
    localparam int HistSz = 8192;

    logic sys_clk;
    logic sys_rst_n;
    logic key_raw;
    logic key_level;
    logic key_press;
    logic key_release;

    key_filter #(
        .CNT_MAX(CntMax)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    typedef struct {
        logic is_press;
        int   edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    logic raw_at[HistSz];
    logic rand_mode = 1'b0;
    logic rand_level = 1'b0;
    int   rand_pulses = 0;

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Edge index and raw pin value sampled by each rising edge.
    always @(posedge sys_clk) begin
        edge_n <= edge_n + 1;
        raw_at[(edge_n + 1) % HistSz] <= key_raw;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Called at a negedge where key_raw just changed: the first sampling edge is
    // edge_n+1, the pulse is visible after edge_n+1+CntMax+1.
    task automatic expect_pulse(input logic is_press);
        exp_t e;
        e.is_press = is_press;
        e.edge_no  = edge_n + int'(CntMax) + 2;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        logic want;
        int   ok;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && (key_press || key_release)) begin
                check("pulse_exclusive", int'(key_press & key_release), 0);
                if (rand_mode) begin
                    want = key_press ? 1'b0 : 1'b1;
                    check("rand_alternate", int'(rand_level), key_press ? 0 : 1);
                    ok = 1;
                    for (int k = 2; k <= int'(CntMax) + 1; k++) begin
                        if (raw_at[(edge_n - k) % HistSz] !== want) ok = 0;
                    end
                    check("rand_stable_run", ok, 1);
                    rand_level = key_press;
                    rand_pulses++;
                    check("rand_level_parity", int'(key_level), int'(rand_level));
                end else if (exp_q.size() == 0) begin
                    check("unexpected_pulse_edge", edge_n, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_press", int'(key_press), int'(e.is_press));
                    check("pulse_edge", edge_n, e.edge_no);
                    check("pulse_level", int'(key_level), int'(e.is_press));
                end
            end
        end
    end

    initial begin
        sys_rst_n = 1'b0;
        key_raw   = 1'b1;
        #15;
        check("rst_level", int'(key_level), 0);
        check("rst_press", int'(key_press), 0);
        check("rst_release", int'(key_release), 0);
        #5 sys_rst_n = 1'b1;
        step(6);

        // Clean press then clean release.
        key_raw = 1'b0;
        expect_pulse(1'b1);
        step(20);
        check("press_level_held", int'(key_level), 1);
        check("press_drained", exp_q.size(), 0);
        key_raw = 1'b1;
        expect_pulse(1'b0);
        step(20);
        check("release_level_held", int'(key_level), 0);
        check("release_drained", exp_q.size(), 0);

        // Bounce: 3 low / 2 high for 30 cycles, then held low.
        for (int i = 0; i < 6; i++) begin
            key_raw = 1'b0;
            step(3);
            key_raw = 1'b1;
            step(2);
        end
        check("bounce_no_level", int'(key_level), 0);
        check("bounce_no_pulse", exp_q.size(), 0);
        key_raw = 1'b0;
        expect_pulse(1'b1);
        step(20);
        check("bounce_level", int'(key_level), 1);
        key_raw = 1'b1;
        expect_pulse(1'b0);
        step(20);
        check("bounce_drained", exp_q.size(), 0);

        // Boundary: 3-cycle low is rejected, 4-cycle low is accepted.
        key_raw = 1'b0;
        step(3);
        key_raw = 1'b1;
        step(15);
        check("short_low_level", int'(key_level), 0);
        key_raw = 1'b0;
        expect_pulse(1'b1);
        step(4);
        key_raw = 1'b1;
        expect_pulse(1'b0);
        step(15);
        check("exact_low_level", int'(key_level), 0);
        check("exact_low_drained", exp_q.size(), 0);

        // Reset while filtering a press with cnt=3.
        key_raw = 1'b0;
        step(5);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midrst_level", int'(key_level), 0);
        check("midrst_press", int'(key_press), 0);
        step(2);
        sys_rst_n = 1'b1;
        expect_pulse(1'b1);
        step(20);
        check("postrst_level", int'(key_level), 1);
        check("postrst_drained", exp_q.size(), 0);

        // Reset while in DOWN clears the level without a clock.
        #2 sys_rst_n = 1'b0;
        #1;
        check("downrst_level", int'(key_level), 0);
        key_raw = 1'b1;
        step(2);
        sys_rst_n = 1'b1;
        step(15);
        check("downrst_quiet", int'(key_level), 0);

        // Random phase: sticky coin flips so long runs occur.
        rand_mode  = 1'b1;
        rand_level = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) key_raw = ~key_raw;
            step(1);
        end
        key_raw = 1'b1;
        step(15);
        check("rand_final_level", int'(key_level), 0);
        check("rand_parity_end", int'(key_level), int'(rand_level));
        check("rand_saw_pulses", int'(rand_pulses > 0), 1);
        rand_mode = 1'b0;

        check("final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
